// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and load-clamp helper for the up/down counter
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Out-of-range load values land on the top of the count range.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - enable-gated prescaler producing one step per PRESCALE enabled cycles
module count_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, clr};
    assign step = en;
  end else begin : g_count
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    assign step = en && (pcnt_q == LAST);

    always_comb begin
      pcnt_d = pcnt_q;
      if (clr) begin
        pcnt_d = '0;
      end else if (en) begin
        pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_d;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - synchronous up/down modulo counter with load, prescale and wrap/saturate
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE %0d must be >= 1", PRESCALE);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step;

  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .step(step)
  );

  // Flag clears are applied first so a same-cycle boundary event overrides them.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;

    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (load) begin
      q_d = WIDTH'(clamp_load(32'(load_val), unsigned'(MODULUS)));
    end else if (step) begin
      tick_d = 1'b1;
      if (up_dn == DIR_UP) begin
        if (q_q == MAX_VAL) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE == MODE_WRAP) begin
            q_d = '0;
          end
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          tc_d  = 1'b1;
          unf_d = 1'b1;
          if (SATURATE == MODE_WRAP) begin
            q_d = MAX_VAL;
          end
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - directed self-checking bench over wrap, saturate and prescaled configs
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, clr_flags;
  logic [3:0] load_val;

  logic [3:0] q_a, q_s, q_p;
  logic       tick_a, tc_a, ovf_a, unf_a;
  logic       tick_s, tc_s, ovf_s, unf_s;
  logic       tick_p, tc_p, ovf_p, unf_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_a), .tick(tick_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a));

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_s), .tick(tick_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut_p (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .q(q_p), .tick(tick_p), .tc(tc_p), .ovf(ovf_p), .unf(unf_p));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected step pattern for the prescaled run: en per edge, then q and tick after it.
  logic       p_en   [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic [3:0] p_q    [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
  logic       p_tick [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
  logic [3:0] dn_q   [4]  = '{1, 0, 9, 8};
  logic [3:0] sat_q  [4]  = '{15, 15, 15, 15};

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clr_flags = 1'b0;
    #2;
    cycle();
    cycle();
    check("rst_q_a", q_a, 0);
    check("rst_flags_a", {tick_a, tc_a, ovf_a, unf_a}, 0);
    check("rst_q_s", q_s, 0);
    check("rst_q_p", q_p, 0);

    // Up count with wrap at MODULUS-1
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      check($sformatf("up_q_%0d", k), q_a, k % 10);
      check($sformatf("up_tick_%0d", k), tick_a, 1);
      check($sformatf("up_tc_%0d", k), tc_a, (k == 10) ? 1 : 0);
      check($sformatf("up_ovf_%0d", k), ovf_a, (k >= 10) ? 1 : 0);
    end

    // Load then count down through the wrap
    load = 1'b1; load_val = 4'd2; up_dn = 1'b0;
    cycle();
    check("ld2_q", q_a, 2);
    check("ld2_tick_tc", {tick_a, tc_a}, 0);
    check("ld2_ovf_kept", ovf_a, 1);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("dn_q_%0d", k), q_a, dn_q[k]);
      check($sformatf("dn_tc_%0d", k), tc_a, (k == 2) ? 1 : 0);
      check($sformatf("dn_unf_%0d", k), unf_a, (k >= 2) ? 1 : 0);
    end

    en = 1'b0; clr_flags = 1'b1;
    cycle();
    check("clr_unf", unf_a, 0);
    check("clr_ovf", ovf_a, 0);
    check("clr_q_frozen", q_a, 8);
    check("clr_tick", tick_a, 0);
    clr_flags = 1'b0;

    load = 1'b1; load_val = 4'd0;
    cycle();
    check("ld0_q", q_a, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0; clr_flags = 1'b1;
    cycle();
    check("setwin_q", q_a, 9);
    check("setwin_tc", tc_a, 1);
    check("setwin_unf", unf_a, 1);
    clr_flags = 1'b0;

    // Saturating instance holds at the top
    rst = 1'b1;
    cycle();
    rst = 1'b0; load = 1'b1; load_val = 4'd14; up_dn = 1'b1; en = 1'b1;
    cycle();
    check("sat_ld_q", q_s, 14);
    check("sat_ld_ovf", ovf_s, 0);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("sat_q_%0d", k), q_s, sat_q[k]);
      check($sformatf("sat_tc_%0d", k), tc_s, (k >= 1) ? 1 : 0);
      check($sformatf("sat_ovf_%0d", k), ovf_s, (k >= 1) ? 1 : 0);
    end

    // Prescale by 3 with an en gap
    rst = 1'b1; en = 1'b0;
    cycle();
    rst = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 11; k++) begin
      en = p_en[k];
      cycle();
      check($sformatf("pre_q_%0d", k), q_p, p_q[k]);
      check($sformatf("pre_tick_%0d", k), tick_p, p_tick[k]);
    end

    // Reset mid-prescale with ovf set
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    cycle();
    check("mid_ld_q", q_p, 9);
    load = 1'b0; en = 1'b1;
    cycle();
    cycle();
    cycle();
    check("mid_wrap_q", q_p, 0);
    check("mid_ovf", ovf_p, 1);
    cycle();
    check("mid_hold_q", q_p, 0);
    rst = 1'b1;
    cycle();
    check("mid_rst_q", q_p, 0);
    check("mid_rst_ovf", ovf_p, 0);
    check("mid_rst_tick", tick_p, 0);
    rst = 1'b0;
    cycle();
    check("post_rst_tick1", tick_p, 0);
    cycle();
    check("post_rst_tick2", tick_p, 0);
    cycle();
    check("post_rst_tick3", tick_p, 1);
    check("post_rst_q", q_p, 1);

    // Load clamp beats a step cycle; rst beats load
    load = 1'b1; load_val = 4'd13; en = 1'b1;
    cycle();
    check("clamp_q", q_a, 9);
    check("clamp_tick_tc", {tick_a, tc_a}, 0);
    check("clamp_q_p", q_p, 9);
    rst = 1'b1; load_val = 4'd5;
    cycle();
    check("rst_load_q_a", q_a, 0);
    check("rst_load_q_p", q_p, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
